// File: rtl/tx_pull_fifo.sv
// Four-entry transmit FIFO feeding a state machine's output shift register.
// Handles explicit PULL, autopull on threshold, overflow flagging and stall generation.
module tx_pull_fifo #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              penable,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pull,
  input  logic              block,
  input  logic              if_empty,
  input  logic              out_req,
  input  logic              auto_pull,
  input  logic [4:0]        pull_thresh,
  input  logic [5:0]        shift_count,
  input  logic [DATA_W-1:0] x_value,
  input  logic              clr_flags,
  output logic              osr_set,
  output logic [DATA_W-1:0] osr_din,
  output logic              stall,
  output logic              full,
  output logic              empty,
  output logic [2:0]        level,
  output logic              tx_over
);

  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [2:0]        level_q, level_d;
  logic              tx_over_q, tx_over_d;
  logic [DATA_W-1:0] mem_q [4];

  logic [5:0]        thresh_val;
  logic              thr;
  logic              sm_en;
  logic              pop;
  logic              push_ok;
  logic              overflow;
  logic [DATA_W-1:0] head;

  assign empty   = (level_q == 3'd0);
  assign full    = (level_q == 3'd4);
  assign level   = level_q;
  assign tx_over = tx_over_q;
  assign head    = mem_q[rd_ptr_q];

  // A threshold field of zero encodes a full 32-bit word.
  assign thresh_val = (pull_thresh == 5'd0) ? 6'd32 : {1'b0, pull_thresh};
  assign thr        = (shift_count >= thresh_val);
  // Holding reset keeps the SM-side strobes quiet regardless of instruction inputs.
  assign sm_en      = penable & reset_n;

  always_comb begin
    osr_set = 1'b0;
    stall   = 1'b0;
    pop     = 1'b0;
    osr_din = empty ? '0 : head;
    if (sm_en) begin
      if (pull) begin
        if (if_empty && !thr) begin
          osr_set = 1'b0;
        end else if (!empty) begin
          pop     = 1'b1;
          osr_set = 1'b1;
          osr_din = head;
        end else if (block) begin
          stall = 1'b1;
        end else begin
          osr_set = 1'b1;
          osr_din = x_value;
        end
      end else if (auto_pull && thr) begin
        // Autopull refills the OSR but an OUT in the same cycle still has to retry.
        stall = out_req;
        if (!empty) begin
          pop     = 1'b1;
          osr_set = 1'b1;
          osr_din = head;
        end
      end
    end
  end

  always_comb begin
    push_ok   = push & (~full | pop);
    overflow  = push & full & ~pop;
    wr_ptr_d  = push_ok ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
    level_d   = level_q + {2'b00, push_ok} - {2'b00, pop};
    tx_over_d = tx_over_q;
    if (overflow) begin
      tx_over_d = 1'b1;
    end else if (clr_flags) begin
      tx_over_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q  <= 2'd0;
      wr_ptr_q  <= 2'd0;
      level_q   <= 3'd0;
      tx_over_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      level_q   <= level_d;
      tx_over_q <= tx_over_d;
    end
  end

  // Storage is not reset; the pointers define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: tb/tb_tx_pull_fifo.sv
// Bench for tx_pull_fifo: directed vector table, hand-written reset sequences,
// then randomized traffic against a queue-based reference model.
module tb_tx_pull_fifo;

  logic        clk;
  logic        reset_n;
  logic        penable;
  logic        push;
  logic [31:0] push_data;
  logic        pull;
  logic        block;
  logic        if_empty;
  logic        out_req;
  logic        auto_pull;
  logic [4:0]  pull_thresh;
  logic [5:0]  shift_count;
  logic [31:0] x_value;
  logic        clr_flags;
  logic        osr_set;
  logic [31:0] osr_din;
  logic        stall;
  logic        full;
  logic        empty;
  logic [2:0]  level;
  logic        tx_over;

  int checks = 0;
  int errors = 0;

  tx_pull_fifo dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .penable     (penable),
    .push        (push),
    .push_data   (push_data),
    .pull        (pull),
    .block       (block),
    .if_empty    (if_empty),
    .out_req     (out_req),
    .auto_pull   (auto_pull),
    .pull_thresh (pull_thresh),
    .shift_count (shift_count),
    .x_value     (x_value),
    .clr_flags   (clr_flags),
    .osr_set     (osr_set),
    .osr_din     (osr_din),
    .stall       (stall),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .tx_over     (tx_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic [31:0] pdata;
    logic        pen;
    logic        pull;
    logic        blk;
    logic        ife;
    logic        oreq;
    logic        ap;
    logic [4:0]  pth;
    logic [5:0]  sc;
    logic [31:0] xv;
    logic        clr;
    logic        e_set;
    logic        e_stall;
    logic [31:0] e_din;
    logic [2:0]  e_lvl;
    logic        e_over;
  } vec_t;

  function automatic vec_t mk(
    input logic [31:0] a_push, input logic [31:0] a_pdata, input logic [31:0] a_pen,
    input logic [31:0] a_pull, input logic [31:0] a_blk, input logic [31:0] a_ife,
    input logic [31:0] a_oreq, input logic [31:0] a_ap, input logic [31:0] a_pth,
    input logic [31:0] a_sc, input logic [31:0] a_xv, input logic [31:0] a_clr,
    input logic [31:0] a_set, input logic [31:0] a_stall, input logic [31:0] a_din,
    input logic [31:0] a_lvl, input logic [31:0] a_over);
    vec_t v;
    v.push = a_push[0];   v.pdata = a_pdata;   v.pen = a_pen[0];
    v.pull = a_pull[0];   v.blk = a_blk[0];    v.ife = a_ife[0];
    v.oreq = a_oreq[0];   v.ap = a_ap[0];      v.pth = a_pth[4:0];
    v.sc = a_sc[5:0];     v.xv = a_xv;         v.clr = a_clr[0];
    v.e_set = a_set[0];   v.e_stall = a_stall[0]; v.e_din = a_din;
    v.e_lvl = a_lvl[2:0]; v.e_over = a_over[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    penable = 1'b1; push = 1'b0; push_data = '0; pull = 1'b0; block = 1'b0;
    if_empty = 1'b0; out_req = 1'b0; auto_pull = 1'b0; pull_thresh = '0;
    shift_count = '0; x_value = '0; clr_flags = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    push = v.push; push_data = v.pdata; penable = v.pen; pull = v.pull;
    block = v.blk; if_empty = v.ife; out_req = v.oreq; auto_pull = v.ap;
    pull_thresh = v.pth; shift_count = v.sc; x_value = v.xv; clr_flags = v.clr;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".level"},   32'(level),   32'd0);
    chk({tag, ".empty"},   32'(empty),   32'd1);
    chk({tag, ".full"},    32'(full),    32'd0);
    chk({tag, ".tx_over"}, 32'(tx_over), 32'd0);
    chk({tag, ".osr_set"}, 32'(osr_set), 32'd0);
    chk({tag, ".stall"},   32'(stall),   32'd0);
  endtask

  localparam logic [31:0] WA = 32'hA0000001, WB = 32'hB0000002, WC = 32'hC0000003;
  localparam logic [31:0] WD = 32'hD0000004, WE = 32'hE0000005;

  vec_t tbl[$];

  // Reference-model state.
  logic [31:0] mq[$];
  logic        m_over;

  initial begin
    // push,pdata,pen,pull,blk,ife,oreq,ap,pth,sc,xv,clr | set,stall,din,lvl,over
    tbl.push_back(mk(1, WA, 1, 0,0,0,0,0, 0, 0, 0, 0,  0,0, 0,  1,0));
    tbl.push_back(mk(1, WB, 1, 0,0,0,0,0, 0, 0, 0, 0,  0,0, WA, 2,0));
    tbl.push_back(mk(1, WC, 1, 0,0,0,0,0, 0, 0, 0, 0,  0,0, WA, 3,0));
    tbl.push_back(mk(1, WD, 1, 0,0,0,0,0, 0, 0, 0, 0,  0,0, WA, 4,0));
    tbl.push_back(mk(1, WE, 1, 0,0,0,0,0, 0, 0, 0, 0,  0,0, WA, 4,1));
    tbl.push_back(mk(0, 0,  1, 1,1,0,0,0, 0, 0, 0, 0,  1,0, WA, 3,1));
    tbl.push_back(mk(0, 0,  1, 1,1,0,0,0, 0, 0, 0, 0,  1,0, WB, 2,1));
    tbl.push_back(mk(0, 0,  1, 1,1,0,0,0, 0, 0, 0, 0,  1,0, WC, 1,1));
    tbl.push_back(mk(0, 0,  1, 1,1,0,0,0, 0, 0, 0, 0,  1,0, WD, 0,1));
    tbl.push_back(mk(0, 0,  1, 0,0,0,0,0, 0, 0, 0, 1,  0,0, 0,  0,0));
    tbl.push_back(mk(0, 0,  1, 1,1,0,0,0, 0, 0, 0, 0,  0,1, 0,  0,0));
    tbl.push_back(mk(0, 0,  1, 1,1,0,0,0, 0, 0, 0, 0,  0,1, 0,  0,0));
    tbl.push_back(mk(0, 0,  1, 1,1,0,0,0, 0, 0, 0, 0,  0,1, 0,  0,0));
    tbl.push_back(mk(1, 32'h1234, 1, 1,1,0,0,0, 0, 0, 0, 0,  0,1, 0, 1,0));
    tbl.push_back(mk(0, 0,  1, 1,1,0,0,0, 0, 0, 0, 0,  1,0, 32'h1234, 0,0));
    tbl.push_back(mk(0, 0,  1, 1,0,0,0,0, 0, 0, 32'hCAFEF00D, 0,  1,0, 32'hCAFEF00D, 0,0));
    tbl.push_back(mk(1, 32'h55, 1, 0,0,0,0,0, 0, 0, 0, 0,  0,0, 0, 1,0));
    tbl.push_back(mk(0, 0,  1, 0,0,0,1,1, 0, 32, 0, 0, 1,1, 32'h55, 0,0));
    tbl.push_back(mk(0, 0,  1, 0,0,0,1,1, 0, 0, 0, 0,  0,0, 0,  0,0));
    tbl.push_back(mk(1, 32'h77, 1, 0,0,0,0,0, 0, 0, 0, 0,  0,0, 0, 1,0));
    tbl.push_back(mk(0, 0,  1, 1,1,1,0,0, 16, 8, 0, 0, 0,0, 32'h77, 1,0));
    tbl.push_back(mk(0, 0,  0, 1,1,0,0,0, 0, 0, 0, 0,  0,0, 32'h77, 1,0));
    tbl.push_back(mk(1, 32'h88, 0, 1,1,0,0,0, 0, 0, 0, 0,  0,0, 32'h77, 2,0));
    tbl.push_back(mk(1, 32'h99, 1, 0,0,0,0,0, 0, 0, 0, 0,  0,0, 32'h77, 3,0));
    tbl.push_back(mk(1, 32'hAA, 1, 0,0,0,0,0, 0, 0, 0, 0,  0,0, 32'h77, 4,0));
    tbl.push_back(mk(1, 32'hBB, 1, 0,0,0,0,0, 0, 0, 0, 1,  0,0, 32'h77, 4,1));
    tbl.push_back(mk(1, 32'hCC, 1, 1,1,0,0,0, 0, 0, 0, 0,  1,0, 32'h77, 4,1));
    tbl.push_back(mk(0, 0,  1, 0,0,0,0,0, 0, 0, 0, 1,  0,0, 32'h88, 4,0));
    tbl.push_back(mk(1, 32'hDD, 1, 1,1,0,0,0, 0, 0, 0, 0,  1,0, 32'h88, 4,0));

    idle_inputs();
    reset_n = 1'b0;
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d.osr_set", i), 32'(osr_set), 32'(tbl[i].e_set));
      chk($sformatf("v%0d.stall", i),   32'(stall),   32'(tbl[i].e_stall));
      chk($sformatf("v%0d.osr_din", i), osr_din,      tbl[i].e_din);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.level", i),   32'(level),   32'(tbl[i].e_lvl));
      chk($sformatf("v%0d.tx_over", i), 32'(tx_over), 32'(tbl[i].e_over));
      chk($sformatf("v%0d.full", i),    32'(full),    32'(tbl[i].e_lvl == 3'd4));
      chk($sformatf("v%0d.empty", i),   32'(empty),   32'(tbl[i].e_lvl == 3'd0));
      @(negedge clk);
    end

    // Full FIFO with simultaneous push and pull, then reset mid-cycle.
    push = 1'b1; push_data = 32'hEE; pull = 1'b1; block = 1'b1;
    #1;
    chk("midrst.osr_din", osr_din, 32'h99);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b1;
    pull = 1'b1; block = 1'b1;
    #1;
    chk("postrst.stall", 32'(stall), 32'd1);
    chk("postrst.osr_set", 32'(osr_set), 32'd0);

    // Stalled PULL interrupted by reset: strobes drop and nothing survives.
    #2;
    reset_n = 1'b0;
    #1;
    chk("stallrst.stall", 32'(stall), 32'd0);
    chk_reset_state("stallrst");
    @(negedge clk);
    reset_n = 1'b1;
    idle_inputs();
    push = 1'b1; push_data = 32'h600D;
    @(negedge clk);
    push = 1'b0; pull = 1'b1; block = 1'b1;
    #1;
    chk("resume.osr_set", 32'(osr_set), 32'd1);
    chk("resume.osr_din", osr_din, 32'h600D);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("resume.empty", 32'(empty), 32'd1);

    // Randomized traffic against the queue model.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    mq.delete();
    m_over = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic        e_set, e_stall, do_pop, thr_m, m_empty;
      logic [31:0] e_din;
      int          thv;
      penable     = ($urandom_range(7, 0) != 0);
      push        = ($urandom_range(1, 0) == 1);
      push_data   = $urandom;
      pull        = ($urandom_range(2, 0) == 0);
      block       = ($urandom_range(1, 0) == 1);
      if_empty    = ($urandom_range(3, 0) == 0);
      out_req     = ($urandom_range(1, 0) == 1);
      auto_pull   = ($urandom_range(1, 0) == 1);
      pull_thresh = 5'($urandom);
      shift_count = 6'($urandom_range(32, 0));
      x_value     = $urandom;
      clr_flags   = ($urandom_range(7, 0) == 0);

      thv     = (pull_thresh == 0) ? 32 : int'(pull_thresh);
      thr_m   = (int'(shift_count) >= thv);
      m_empty = (mq.size() == 0);
      e_set = 1'b0; e_stall = 1'b0; do_pop = 1'b0;
      e_din = m_empty ? 32'd0 : mq[0];
      if (penable) begin
        if (pull) begin
          if (!(if_empty && !thr_m)) begin
            if (!m_empty) begin
              do_pop = 1'b1; e_set = 1'b1; e_din = mq[0];
            end else if (block) begin
              e_stall = 1'b1;
            end else begin
              e_set = 1'b1; e_din = x_value;
            end
          end
        end else if (auto_pull && thr_m) begin
          e_stall = out_req;
          if (!m_empty) begin
            do_pop = 1'b1; e_set = 1'b1; e_din = mq[0];
          end
        end
      end
      #1;
      chk("rnd.osr_set", 32'(osr_set), 32'(e_set));
      chk("rnd.stall",   32'(stall),   32'(e_stall));
      chk("rnd.osr_din", osr_din,      e_din);

      if (push && mq.size() == 4 && !do_pop) m_over = 1'b1;
      else if (clr_flags) m_over = 1'b0;
      if (do_pop) void'(mq.pop_front());
      if (push && mq.size() < 4) mq.push_back(push_data);

      @(posedge clk);
      #1;
      chk("rnd.level",   32'(level),   mq.size());
      chk("rnd.tx_over", 32'(tx_over), 32'(m_over));
      chk("rnd.full",    32'(full),    32'(mq.size() == 4));
      chk("rnd.empty",   32'(empty),   32'(mq.size() == 0));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_pull_fifo.md
TX_PULL_FIFO -- requirements
Module: tx_pull_fifo

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: penable  in  1  state-machine clock enable; SM-side actions occur only when high.
REQ-004 SHALL have: push  in  1 / push_data  in  32  system-side write strobe and word.
REQ-005 SHALL have: pull  in  1 / block  in  1 / if_empty  in  1  PULL instruction executing, its Block bit, its IfEmpty bit.
REQ-006 SHALL have: out_req  in  1  OUT instruction executing this cycle.
REQ-007 SHALL have: auto_pull  in  1 / pull_thresh  in  5  autopull enable; threshold, 0 meaning 32.
REQ-008 SHALL have: shift_count  in  6  OSR shift count, 0..32.
REQ-009 SHALL have: x_value  in  32  scratch X, loaded by a non-blocking PULL on empty FIFO.
REQ-010 SHALL have: clr_flags  in  1  clears the sticky overflow flag.
REQ-011 SHALL have: osr_set  out  1 / osr_din  out  32  OSR load strobe and data.
REQ-012 SHALL have: stall  out  1  current instruction must repeat next cycle.
REQ-013 SHALL have: full  out  1 / empty  out  1 / level  out  3  FIFO status, level 0..4.
REQ-014 SHALL have: tx_over  out  1  sticky: push attempted while full.

Function
REQ-015 SHALL store up to 4 words of 32 bits in FIFO order, using 2-bit read/write pointers that wrap 3->0.
REQ-016 SHALL define thresh_val = 32 when pull_thresh==0, else pull_thresh, and define thr = (shift_count >= thresh_val).
REQ-017 SHALL define pop as SM-side removal of the head word, effective at the clock edge and only when penable=1 and empty=0.
REQ-018 SHALL accept push when full=0, or when full=1 and a pop occurs in the same cycle; push is independent of penable.
REQ-019 SHALL drop a push when full=1 with no same-cycle pop, leave contents unchanged, and set tx_over to 1 at the next edge.
REQ-020 SHALL clear tx_over on clr_flags; a same-cycle overflow SHALL take priority and leave tx_over set.
REQ-021 SHALL, when empty=1, accept a push and perform no pop in that cycle; the pushed word SHALL become visible the following cycle.
REQ-022 SHALL combinationally decode an explicit PULL, applied when pull=1 and penable=1, in this order:
  - if_empty=1 and thr=0: no-op; osr_set=0, stall=0.
  - empty=0: pop; osr_set=1, osr_din=head word, stall=0.
  - empty=1 and block=1: osr_set=0, stall=1.
  - empty=1 and block=0: osr_set=1, osr_din=x_value, stall=0.
REQ-023 SHALL combinationally decode autopull, applied when auto_pull=1, pull=0, penable=1 and thr=1:
  - empty=0: pop; osr_set=1, osr_din=head word; stall = out_req.
  - empty=1: osr_set=0; stall = out_req.
REQ-024 SHALL, when no case of REQ-022 or REQ-023 applies, drive osr_set=0 and stall=0, and drive osr_din with the head word, or 0 when empty.
REQ-025 SHALL force osr_set=0 and stall=0 whenever penable=0.
REQ-026 SHALL update full, empty and level registered, from the pointers and count after each edge; level SHALL equal pushes accepted minus pops.
REQ-027 SHALL update level by 0 when a push and a pop occur in the same cycle.

Reset
REQ-028 SHALL, while reset_n=0, asynchronously clear both pointers, set level=0, empty=1, full=0 and tx_over=0; combinational outputs SHALL follow, giving osr_set=0 and stall=0.
REQ-029 SHALL discard all FIFO contents on reset assertion mid-operation, including during a stalled PULL; RAM contents need not be cleared.
REQ-030 SHALL resume normal operation on the first rising edge after reset_n deasserts.

Verification
REQ-031 SHALL be verified by: push A,B,C,D then a fifth word E -> full=1, level=4, tx_over=1; four PULLs return A,B,C,D in order; empty=1.
REQ-032 SHALL be verified by: blocking PULL on empty FIFO for 3 cycles, then push 0x1234 -> stall=1 for those cycles; next cycle osr_set=1, osr_din=0x1234, stall=0.
REQ-033 SHALL be verified by: non-blocking PULL on empty FIFO with x_value=0xCAFEF00D -> osr_set=1, osr_din=0xCAFEF00D, level stays 0.
REQ-034 SHALL be verified by: auto_pull=1, pull_thresh=0, shift_count=32, out_req=1, FIFO holding 0x55 -> osr_set=1, stall=1, level 1->0; then with shift_count=0 -> stall=0.
REQ-035 SHALL be verified by: PULL with if_empty=1, shift_count=8, pull_thresh=16, FIFO holding 1 word -> osr_set=0, level unchanged.
REQ-036 SHALL be verified by: push and pull in the same cycle while full=1, then reset_n pulsed low mid-stream -> level stays 4 with no overflow; after reset, level=0, empty=1, tx_over=0.
